// File: rtl/frame_sram_responder.sv
// Splits each 32-bit client request into two 16-bit async-SRAM accesses; optional range check via FRAME_SRAM_ADDR_CHECK_EN.
// Latency 2*(2+WAIT_STATES) cycles from acceptance; pause holds the client for exactly that long, one request per 2*(2+WAIT_STATES)+1 cycles.
module frame_sram_responder #(
   parameter int WAIT_STATES = 0,
   parameter int FRAME_WORDS = 76800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_en,
   input  logic [17:0] address,
   input  logic [31:0] data_write,
   input  logic        wren,
   output logic [31:0] data_read,
   output logic        pause,
   output logic [18:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        addr_error
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LO_SETUP  = 3'd1;
   localparam logic [2:0] LO_STROBE = 3'd2;
   localparam logic [2:0] HI_SETUP  = 3'd3;
   localparam logic [2:0] HI_STROBE = 3'd4;

   localparam logic [2:0] LAST_STROBE = 3'(WAIT_STATES);

   typedef struct packed {
      logic [17:0] addr;
      logic [31:0] dat;
      logic        wr;
      logic        bad;
   } req_t;

   logic [2:0]  state;
   logic [2:0]  cnt;
   req_t        req_q;
   logic [15:0] lo_hold;
   logic        req_bad;
   logic        hi_half;
   logic        in_setup;
   logic        in_strobe;
   logic        active;

`ifdef FRAME_SRAM_ADDR_CHECK_EN
   assign req_bad = (32'(address) >= 32'(FRAME_WORDS));
`else
   assign req_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         req_q      <= '0;
         lo_hold    <= 16'd0;
         data_read  <= 32'd0;
         addr_error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_en) begin
                  req_q      <= '{addr: address, dat: data_write, wr: wren, bad: req_bad};
                  addr_error <= addr_error | req_bad;
                  state      <= LO_SETUP;
               end
            end
            LO_SETUP: begin
               cnt   <= 3'd0;
               state <= LO_STROBE;
            end
            LO_STROBE: begin
               if (cnt == LAST_STROBE) begin
                  lo_hold <= sram_dq_in;
                  state   <= HI_SETUP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            HI_SETUP: begin
               cnt   <= 3'd0;
               state <= HI_STROBE;
            end
            HI_STROBE: begin
               if (cnt == LAST_STROBE) begin
                  // Out-of-range reads never touched the SRAM, so they return zero.
                  if (!req_q.wr)
                     data_read <= req_q.bad ? 32'd0 : {sram_dq_in, lo_hold};
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so reset drops them without waiting for a clock.
   assign hi_half   = (state == HI_SETUP) || (state == HI_STROBE);
   assign in_setup  = (state == LO_SETUP) || (state == HI_SETUP);
   assign in_strobe = (state == LO_STROBE) || (state == HI_STROBE);
   assign active    = (in_setup || in_strobe) && !req_q.bad;

   assign pause       = (state != IDLE);
   assign sram_addr   = {req_q.addr, hi_half};
   assign sram_dq_out = hi_half ? req_q.dat[31:16] : req_q.dat[15:0];
   assign sram_ce_n   = !active;
   assign sram_oe_n   = !(active && !req_q.wr);
   assign sram_we_n   = !(active && in_strobe && req_q.wr);
   assign sram_dq_oe  = active && req_q.wr;

endmodule

// File: tb/tb_frame_sram_responder.sv
// Bench for frame_sram_responder: a WAIT_STATES=0 instance with an SRAM model and a WAIT_STATES=3 instance driven by hand.
module tb_frame_sram_responder;

   logic clk;
   logic rst_n;

   logic        req_en0, wren0, dq_oe0, ce_n0, oe_n0, we_n0, pause0, addr_error0;
   logic [17:0] address0;
   logic [31:0] data_write0, data_read0;
   logic [18:0] sram_addr0;
   logic [15:0] dq_out0, dq_in0;

   logic        req_en3, wren3, dq_oe3, ce_n3, oe_n3, we_n3, pause3, addr_error3;
   logic [17:0] address3;
   logic [31:0] data_write3, data_read3;
   logic [18:0] sram_addr3;
   logic [15:0] dq_out3, dq_in3;

   frame_sram_responder #(.WAIT_STATES(0), .FRAME_WORDS(76800)) u0 (
      .clk(clk), .rst_n(rst_n), .req_en(req_en0), .address(address0),
      .data_write(data_write0), .wren(wren0), .data_read(data_read0), .pause(pause0),
      .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
      .sram_dq_oe(dq_oe0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0),
      .addr_error(addr_error0));

   frame_sram_responder #(.WAIT_STATES(3), .FRAME_WORDS(76800)) u3 (
      .clk(clk), .rst_n(rst_n), .req_en(req_en3), .address(address3),
      .data_write(data_write3), .wren(wren3), .data_read(data_read3), .pause(pause3),
      .sram_addr(sram_addr3), .sram_dq_out(dq_out3), .sram_dq_in(dq_in3),
      .sram_dq_oe(dq_oe3), .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_we_n(we_n3),
      .addr_error(addr_error3));

   int total = 0;
   int bad = 0;
   int cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Half-word SRAM model: writes land while we_n is low, reads present stored data (5A5A if never written).
   logic [15:0] mem0 [int];
   always @(negedge clk) begin
      if (!ce_n0 && !we_n0) mem0[int'(sram_addr0)] = dq_out0;
      if (!ce_n0 && !oe_n0 && mem0.exists(int'(sram_addr0))) dq_in0 = mem0[int'(sram_addr0)];
      else dq_in0 = 16'h5A5A;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   logic [18:0] obs_addr [0:15];
   logic        obs_we   [0:15];
   logic        obs_ce   [0:15];

   // One request on u0; obs_* index 0 is the first cycle after acceptance.
   task automatic run0(input logic w, input logic [17:0] a, input logic [31:0] d,
                       output int pc, output logic [31:0] rd);
      @(negedge clk);
      req_en0 = 1'b1; wren0 = w; address0 = a; data_write0 = d;
      @(posedge clk);
      #1 req_en0 = 1'b0;
      pc = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         obs_addr[i] = sram_addr0; obs_we[i] = we_n0; obs_ce[i] = ce_n0;
         check("oe_dq_excl", {31'd0, dq_oe0 & ~oe_n0}, 32'd0);
         if (!pause0) break;
         pc++;
      end
      rd = data_read0;
   endtask

   typedef struct {
      logic        w;
      logic [17:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t        tbl [9];
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd;
   logic [31:0] rd;
   logic [17:0] ra;
   logic        rw;
   logic [31:0] rdat;
   int          pc, ph, cnt_a, cnt_b, idx, naddr;
   int          acc_t [3];
   logic [18:0] alist [0:15];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req_en0 = 0; wren0 = 0; address0 = '0; data_write0 = '0;
      req_en3 = 0; wren3 = 0; address3 = '0; data_write3 = '0; dq_in3 = 16'h0;

      tbl[0] = '{1'b1, 18'd2240,  32'hDEADBEEF, 32'h00000000};
      tbl[1] = '{1'b0, 18'd2240,  32'h0,        32'hDEADBEEF};
      tbl[2] = '{1'b1, 18'd0,     32'h12345678, 32'hDEADBEEF};
      tbl[3] = '{1'b0, 18'd0,     32'h0,        32'h12345678};
      tbl[4] = '{1'b1, 18'd74561, 32'hA5A50F0F, 32'h12345678};
      tbl[5] = '{1'b0, 18'd74561, 32'h0,        32'hA5A50F0F};
      tbl[6] = '{1'b1, 18'd1,     32'hFFFF0000, 32'hA5A50F0F};
      tbl[7] = '{1'b0, 18'd2240,  32'h0,        32'hDEADBEEF};
      tbl[8] = '{1'b0, 18'd1,     32'h0,        32'hFFFF0000};

      #3;
      check("rst_ctl0", {26'd0, ce_n0, oe_n0, we_n0, dq_oe0, pause0, addr_error0}, 32'h38);
      check("rst_ctl3", {26'd0, ce_n3, oe_n3, we_n3, dq_oe3, pause3, addr_error3}, 32'h38);
      check("rst_rd0", data_read0, 32'd0);
      check("rst_addr0", 32'(sram_addr0), 32'd0);
      check("rst_dq0", 32'(dq_out0), 32'd0);
      #20 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run0(tbl[i].w, tbl[i].a, tbl[i].d, pc, rd);
         check("tbl_rd", rd, tbl[i].exp_rd);
         check("tbl_pause", 32'(pc), 32'd4);
         if (i == 0) begin
            check("w_addr_c1", 32'(obs_addr[0]), 32'd4480);
            check("w_addr_c2", 32'(obs_addr[1]), 32'd4480);
            check("w_addr_c3", 32'(obs_addr[2]), 32'd4481);
            check("w_addr_c4", 32'(obs_addr[3]), 32'd4481);
            check("w_we_seq", {27'd0, obs_we[0], obs_we[1], obs_we[2], obs_we[3], obs_we[4]}, 32'b10101);
            check("w_mem_lo", 32'(mem0[4480]), 32'hBEEF);
            check("w_mem_hi", 32'(mem0[4481]), 32'hDEAD);
         end
      end

      last_rd = 32'hFFFF0000;
      for (int n = 0; n < 40; n++) begin
         ra = 18'(1000 + $urandom_range(0, 15));
         rw = 1'($urandom_range(0, 1));
         rdat = $urandom;
         if (!rw && !ref_mem.exists(int'(ra))) rw = 1'b1;
         run0(rw, ra, rdat, pc, rd);
         if (rw) ref_mem[int'(ra)] = rdat;
         else last_rd = ref_mem[int'(ra)];
         check("rnd_rd", rd, last_rd);
         check("rnd_pause", 32'(pc), 32'd4);
      end

`ifdef FRAME_SRAM_ADDR_CHECK_EN
      run0(1'b0, 18'd74561, 32'h0, pc, rd);
      check("rng_ok_rd", rd, 32'hA5A50F0F);
      check("rng_ok_err", 32'(addr_error0), 32'd0);
      check("rng_ok_ce", 32'(obs_ce[0]), 32'd0);
      run0(1'b0, 18'd76800, 32'h0, pc, rd);
      check("rng_bad_rd", rd, 32'd0);
      check("rng_bad_err", 32'(addr_error0), 32'd1);
      check("rng_bad_pause", 32'(pc), 32'd4);
      check("rng_bad_ce", {28'd0, obs_ce[0], obs_ce[1], obs_ce[2], obs_ce[3]}, 32'hF);
      run0(1'b0, 18'd74561, 32'h0, pc, rd);
      check("rng_sticky", 32'(addr_error0), 32'd1);
      check("rng_after_rd", rd, 32'hA5A50F0F);
`else
      run0(1'b0, 18'd76800, 32'h0, pc, rd);
      check("nochk_err", 32'(addr_error0), 32'd0);
      check("nochk_ce", 32'(obs_ce[0]), 32'd0);
      check("nochk_addr", 32'(obs_addr[2]), 32'd153601);
      check("nochk_pause", 32'(pc), 32'd4);
`endif

      // WAIT_STATES=3 write: each half has 1 setup plus 4 strobe cycles.
      @(negedge clk);
      req_en3 = 1'b1; wren3 = 1'b1; address3 = 18'd7; data_write3 = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_en3 = 1'b0;
      ph = 0; cnt_a = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (pause3) ph++;
         if (!we_n3) cnt_a++;
         if (k == 1) check("w3_setup_we", 32'(we_n3), 32'd1);
         if (k == 5) check("w3_lo_dq", 32'(dq_out3), 32'hF00D);
         if (k == 6) check("w3_hi_setup", {12'd0, sram_addr3, we_n3}, {12'd0, 19'd15, 1'b1});
         if (k == 10) check("w3_hi_dq", 32'(dq_out3), 32'hCAFE);
      end
      check("w3_pause", 32'(ph), 32'd10);
      check("w3_we_cycles", 32'(cnt_a), 32'd8);

      // WAIT_STATES=3 read: only the last strobe cycle of each half carries good data.
      @(negedge clk);
      req_en3 = 1'b1; wren3 = 1'b0; address3 = 18'd7;
      @(posedge clk);
      #1 req_en3 = 1'b0;
      ph = 0; cnt_a = 0;
      for (int k = 1; k <= 14; k++) begin
         dq_in3 = (k == 5) ? 16'hC0DE : (k == 10) ? 16'hF00D : 16'(16'h1000 + k);
         @(negedge clk);
         if (pause3) ph++;
         if (!oe_n3) cnt_a++;
         if (k == 10) check("r3_not_early", data_read3, 32'd0);
         @(posedge clk);
         #1;
      end
      check("r3_pause", 32'(ph), 32'd10);
      check("r3_oe_cycles", 32'(cnt_a), 32'd10);
      check("r3_data", data_read3, 32'hF00DC0DE);

      // Back-to-back reads with req_en held high.
      wren0 = 1'b0; idx = 0; naddr = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!ce_n0 && (naddr == 0 || sram_addr0 != alist[naddr-1]) && naddr < 16) begin
            alist[naddr] = sram_addr0;
            naddr++;
         end
         if (!pause0) begin
            if (idx < 3) begin
               req_en0 = 1'b1; address0 = 18'(320 + idx); acc_t[idx] = cyc; idx++;
            end else begin
               req_en0 = 1'b0;
               break;
            end
         end
      end
      check("b2b_count", 32'(naddr), 32'd6);
      for (int j = 0; j < 6; j++)
         if (j < naddr) check("b2b_addr", 32'(alist[j]), 32'(640 + j));
      check("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd5);
      check("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd5);

      // req_en held one extra cycle after acceptance, then dropped.
      @(negedge clk);
      req_en0 = 1'b1; wren0 = 1'b0; address0 = 18'd2240;
      @(posedge clk);
      ph = 0; cnt_b = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (pause0) ph++;
         else if (!ce_n0) cnt_b++;
         if (i == 0) begin
            @(posedge clk);
            #1 req_en0 = 1'b0;
         end
      end
      check("drop_pause", 32'(ph), 32'd4);
      check("drop_idle_act", 32'(cnt_b), 32'd0);
      check("drop_rd", data_read0, 32'hDEADBEEF);

      // Reset asynchronously in the low-half strobe of a write.
      @(negedge clk);
      req_en0 = 1'b1; wren0 = 1'b1; address0 = 18'd5000; data_write0 = 32'h11112222;
      @(posedge clk);
      #1 req_en0 = 1'b0;
      @(posedge clk);
      #3 check("mid_we_low", 32'(we_n0), 32'd0);
      rst_n = 1'b0;
      #1 check("mid_rst_ctl", {29'd0, we_n0, dq_oe0, pause0}, 32'b100);
      #10 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", {30'd0, pause0, ce_n0}, 32'b01);
      check("post_rst_rd", data_read0, 32'd0);
      run0(1'b0, 18'd2240, 32'h0, pc, rd);
      check("post_rst_read", rd, 32'hDEADBEEF);
      check("post_rst_pause", 32'(pc), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_sram_responder.md
Name: frame_sram_responder

Overview:
- Memory-side responder for the frame-buffer port used by the image-processing stages (pixel filling, edge detection, etc.).
- Each stage acts as initiator, driving address/data_write/wren and sampling data_read, and freezes while pause is high.
- This block services each 32-bit request on a 16-bit external asynchronous SRAM as two half-word accesses. It holds pause high until the access completes.

Parameters:
WAIT_STATES, 0, extra strobe cycles per half-word access (0..7)
FRAME_WORDS, 76800, number of valid 32-bit frame words (320x240); used only by the optional feature

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_en  input  1  high while the active stage owns the port; each unpaused cycle with req_en=1 is one request
address  input  18  client 32-bit word address
data_write  input  32  client write data
wren  input  1  1=write request, 0=read request
data_read  output  32  last completed read word
pause  output  1  stall to client; client must hold all state while high
sram_addr  output  19  external half-word address
sram_dq_out  output  16  external write data
sram_dq_in  input  16  external read data
sram_dq_oe  output  1  drive enable for the external data pins
sram_ce_n  output  1  chip enable, active low
sram_oe_n  output  1  output enable, active low
sram_we_n  output  1  write enable, active low
addr_error  output  1  sticky out-of-range flag (tied 0 without the feature)

Behaviour:
- Reset (async, immediate, including mid-transaction): state=IDLE; pause=0; data_read=0; sram_ce_n, sram_oe_n and sram_we_n all =1; sram_dq_oe=0; sram_addr=0; sram_dq_out=0; addr_error=0.
- FSM states: IDLE, LO_SETUP, LO_STROBE, HI_SETUP, HI_STROBE.
- IDLE:
  - When req_en=1, the rising edge latches address, data_write and wren, sets pause=1, and moves to LO_SETUP.
  - When req_en=0, stay in IDLE with pause=0.
- LO half: sram_addr={address,1'b0}, data bits [15:0].
- HI half: sram_addr={address,1'b1}, data bits [31:16].
- SETUP state (1 cycle):
  - sram_ce_n=0; sram_we_n=1.
  - Read: sram_oe_n=0.
  - Write: sram_oe_n=1, sram_dq_oe=1, and sram_dq_out carries the half's data.
- STROBE state (1+WAIT_STATES cycles, counted by a 3-bit counter):
  - Write: sram_we_n=0 throughout.
  - Read: sram_oe_n=0; sram_dq_in is captured on the last strobe cycle into the half's lane of a holding register.
- SETUP between halves returns sram_we_n high, so each half-word is latched on a clean we_n rising edge; the address changes only while we_n=1.
- On the edge ending HI_STROBE:
  - Return to IDLE with pause=0.
  - Read: data_read is updated with the full 32-bit word in that same edge.
  - Write: data_read is unchanged.
- Controls go inactive (ce/oe/we high, dq_oe=0) in IDLE.
- Timing:
  - pause is high for exactly 2*(2+WAIT_STATES) cycles per request.
  - Latency from request edge to data_read valid is 2*(2+WAIT_STATES) cycles.
  - Throughput is one request per 2*(2+WAIT_STATES)+1 cycles.
- data_read holds its value until the next read completes.
- If req_en falls mid-transaction, the transaction still completes, and no new request is accepted afterwards.
- A request is accepted only from IDLE, so a request can never collide with a transaction in flight.
- sram_dq_oe and sram_oe_n are never both asserted in the same cycle.

Optional Feature:
- Macro FRAME_SRAM_ADDR_CHECK_EN.
- When defined, a request with address >= FRAME_WORDS:
  - sets addr_error=1 (sticky until reset);
  - keeps sram_ce_n high and suppresses all SRAM strobes;
  - still runs the full pause timing;
  - for a read, returns data_read=0.
- When not defined: no range check is made, all addresses go to the SRAM, and addr_error is constant 0.

Test Plan:
- Write then read, WAIT_STATES=0: write 0xDEADBEEF to address 2240 -> half-word 0xBEEF at sram_addr 4480 and 0xDEAD at 4481, each with a single-cycle we_n pulse; pause high for 4 cycles. Then read address 2240 -> data_read=0xDEADBEEF on the 4th edge after acceptance.
- WAIT_STATES=3: read request -> pause high for 10 cycles; strobe lasts 4 cycles per half; sram_dq_in is sampled only on the last strobe cycle (model changes data earlier to prove this).
- Back-to-back requests with req_en held high: requests at 320, 321, 322 -> accepted at 5-cycle intervals; sram_addr sequence 640,641,642,643,644,645.
- Reset asserted in LO_STROBE of a write -> sram_we_n=1, sram_dq_oe=0 and pause=0 immediately, without waiting for a clock edge; after release the FSM is in IDLE and data_read=0.
- req_en dropped one cycle after acceptance -> the transaction finishes, pause falls, and no further SRAM activity occurs.
- With FRAME_SRAM_ADDR_CHECK_EN: read address 74561 -> normal access. Read address 76800 -> addr_error=1, data_read=0, sram_ce_n stays high, pause still 4 cycles.
